// File: rtl/cache_trace_driver.sv
// Trace replay source for the cache model: buffers host-loaded accesses and
// presents them one at a time on a valid/ready port with a fixed idle gap.
module cache_trace_driver #(
  parameter int DEPTH      = 64,
  parameter int ADDR_W     = 48,
  parameter int GAP_CYCLES = 2,
  parameter int CNT_W      = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              load_valid,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic              load_is_write,
  output logic              load_ready,
  output logic              overflow,
  input  logic              start,
  input  logic              lvl_sel,
  output logic              cache_valid,
  input  logic              cache_ready,
  output logic [ADDR_W-1:0] cache_addr,
  output logic [7:0]        cache_op,
  output logic              cache_lvl,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  num_issued,
  output logic [CNT_W-1:0]  num_rd,
  output logic [CNT_W-1:0]  num_wr
);

  localparam int PW = $clog2(DEPTH);
  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [7:0]   OP_RD = 8'h52;
  localparam logic [7:0]   OP_WR = 8'h57;
  localparam logic [PW:0]  PTR_ONE = (PW + 1)'(1);
  localparam logic [PW:0]  FULL = (PW + 1)'(DEPTH);
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES);
  localparam logic [GW-1:0] GAP_ONE = GW'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, ISSUE, GAP, DONE} state_t;

  state_t state, state_nxt;

  // Entry layout: {is_write, addr}
  logic [ADDR_W:0] mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW:0]     count;
  logic [PW:0]     rd_ptr;
  logic [PW:0]     rd_ptr_inc;
  logic [PW:0]     pres_ptr;
  logic [GW-1:0]   gap_cnt;
  logic [ADDR_W:0] pres_entry;

  logic idle_like, do_clear, do_start, do_load, xfer, last, gap_end, present;

  assign idle_like  = (state == IDLE) || (state == DONE);
  assign do_clear   = idle_like && clear;
  assign do_start   = idle_like && start && !clear;
  assign load_ready = idle_like && (count != FULL);
  assign do_load    = load_valid && load_ready && !clear;
  assign xfer       = (state == ISSUE) && cache_valid && cache_ready;
  assign rd_ptr_inc = rd_ptr + PTR_ONE;
  assign last       = (rd_ptr_inc == count);
  assign gap_end    = (state == GAP) && (gap_cnt == GAP_ONE);
  assign busy       = (state == ISSUE) || (state == GAP);
  assign done       = (state == DONE);

  // The final gap cycle loads the next entry so the idle time is exactly GAP_CYCLES.
  assign present  = ((state == ISSUE) && !cache_valid) || gap_end ||
                    (xfer && !last && (GAP_CYCLES == 0));
  assign pres_ptr = xfer ? rd_ptr_inc : rd_ptr;
  assign pres_entry = mem[pres_ptr[PW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (do_start) state_nxt = (count == '0) ? DONE : ISSUE;
      end
      ISSUE: begin
        if (xfer) begin
          if (last)                state_nxt = DONE;
          else if (GAP_CYCLES > 0) state_nxt = GAP;
        end
      end
      GAP: begin
        if (gap_end) state_nxt = ISSUE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (do_load) mem[wr_ptr] <= {load_is_write, load_addr};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count    <= '0;
      wr_ptr   <= '0;
      overflow <= 1'b0;
    end else if (do_clear) begin
      count    <= '0;
      wr_ptr   <= '0;
      overflow <= 1'b0;
    end else if (do_load) begin
      count    <= count + PTR_ONE;
      wr_ptr   <= wr_ptr + PW'(1);
    end else if (idle_like && load_valid && (count == FULL)) begin
      overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr     <= '0;
      gap_cnt    <= '0;
      cache_lvl  <= 1'b0;
      num_issued <= '0;
      num_rd     <= '0;
      num_wr     <= '0;
    end else if (do_start) begin
      rd_ptr     <= '0;
      cache_lvl  <= lvl_sel;
      num_issued <= '0;
      num_rd     <= '0;
      num_wr     <= '0;
    end else if (xfer) begin
      rd_ptr     <= rd_ptr_inc;
      gap_cnt    <= GAP_LOAD;
      num_issued <= num_issued + CNT_ONE;
      if (cache_op == OP_WR) num_wr <= num_wr + CNT_ONE;
      else                   num_rd <= num_rd + CNT_ONE;
    end else if (state == GAP) begin
      gap_cnt    <= gap_cnt - GAP_ONE;
    end
  end

  // Address/op only change when a new entry is presented, never on valid drop.
  always_ff @(posedge clk) begin
    if (reset) begin
      cache_valid <= 1'b0;
      cache_addr  <= '0;
      cache_op    <= 8'h00;
    end else if (present) begin
      cache_valid <= 1'b1;
      cache_addr  <= pres_entry[ADDR_W-1:0];
      cache_op    <= pres_entry[ADDR_W] ? OP_WR : OP_RD;
    end else if (xfer) begin
      cache_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cache_trace_driver.sv
// Directed + randomized bench for cache_trace_driver against a queue-based trace model.
module tb_cache_trace_driver;

  localparam int DEPTH      = 64;
  localparam int ADDR_W     = 48;
  localparam int GAP_CYCLES = 2;
  localparam int CNT_W      = 12;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              clear = 1'b0;
  logic              load_valid = 1'b0;
  logic [ADDR_W-1:0] load_addr = '0;
  logic              load_is_write = 1'b0;
  logic              load_ready;
  logic              overflow;
  logic              start = 1'b0;
  logic              lvl_sel = 1'b0;
  logic              cache_valid;
  logic              cache_ready = 1'b0;
  logic [ADDR_W-1:0] cache_addr;
  logic [7:0]        cache_op;
  logic              cache_lvl;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  num_issued, num_rd, num_wr;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: the trace exactly as the host loaded it.
  logic [ADDR_W-1:0] m_addr[$];
  bit                m_w[$];
  bit                m_ovf = 0;

  cache_trace_driver #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .GAP_CYCLES(GAP_CYCLES), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .clear(clear), .load_valid(load_valid), .load_addr(load_addr),
    .load_is_write(load_is_write), .load_ready(load_ready), .overflow(overflow), .start(start),
    .lvl_sel(lvl_sel), .cache_valid(cache_valid), .cache_ready(cache_ready),
    .cache_addr(cache_addr), .cache_op(cache_op), .cache_lvl(cache_lvl), .busy(busy),
    .done(done), .num_issued(num_issued), .num_rd(num_rd), .num_wr(num_wr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_state();
    chk("rst_valid", cache_valid, 0);
    chk("rst_addr", cache_addr, 0);
    chk("rst_op", cache_op, 8'h00);
    chk("rst_lvl", cache_lvl, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_load_ready", load_ready, 1);
    chk("rst_issued", num_issued, 0);
    chk("rst_rd", num_rd, 0);
    chk("rst_wr", num_wr, 0);
  endtask

  task automatic load_entry(input logic [ADDR_W-1:0] a, input bit w);
    chk("load_ready", load_ready, m_addr.size() < DEPTH);
    load_valid = 1'b1; load_addr = a; load_is_write = w;
    @(negedge clk);
    load_valid = 1'b0;
    if (m_addr.size() < DEPTH) begin
      m_addr.push_back(a);
      m_w.push_back(w);
    end else begin
      m_ovf = 1;
    end
    chk("overflow", overflow, m_ovf);
  endtask

  task automatic replay(input logic lvl, input int rdy_pct, input int stall_idx, input int stall_len);
    int n, idx, cyc, gap, stalls, exp_wr;
    bit after_xfer, prev_stall;
    logic [ADDR_W-1:0] prev_addr;
    n = m_addr.size(); idx = 0; cyc = 0; gap = 0; stalls = 0; exp_wr = 0;
    after_xfer = 0; prev_stall = 0; prev_addr = '0;
    foreach (m_w[i]) if (m_w[i]) exp_wr++;
    start = 1'b1; lvl_sel = lvl;
    @(negedge clk);
    start = 1'b0;
    chk("start_cnt_zero", num_issued, 0);
    chk("start_no_valid_yet", cache_valid, 0);
    if (n == 0) begin
      chk("empty_done", done, 1);
      chk("empty_busy", busy, 0);
      @(negedge clk);
      chk("empty_never_valid", cache_valid, 0);
      chk("empty_rd", num_rd, 0);
      chk("empty_wr", num_wr, 0);
      return;
    end
    chk("start_busy", busy, 1);
    @(negedge clk);
    chk("first_valid_latency", cache_valid, 1);
    while (idx < n && cyc < 4000) begin
      load_valid = 1'($urandom_range(1));
      load_addr = ADDR_W'({$urandom, $urandom});
      load_is_write = 1'($urandom_range(1));
      if (prev_stall) begin
        chk("stall_valid_held", cache_valid, 1);
        chk("stall_addr_held", cache_addr, prev_addr);
      end
      if (cache_valid) begin
        if (after_xfer) begin
          chk("gap_len", gap, GAP_CYCLES);
          after_xfer = 0;
        end
        if (idx == stall_idx && stalls < stall_len) begin
          cache_ready = 1'b0;
          stalls++;
        end else begin
          cache_ready = ($urandom_range(99) < rdy_pct);
        end
        chk("issued_before_xfer", num_issued, idx);
        if (cache_ready) begin
          chk("addr", cache_addr, m_addr[idx]);
          chk("op", cache_op, m_w[idx] ? 8'h57 : 8'h52);
          chk("lvl", cache_lvl, lvl);
          idx++;
          after_xfer = 1; gap = 0; prev_stall = 0;
        end else begin
          prev_stall = 1;
          prev_addr = cache_addr;
        end
      end else begin
        gap++;
        cache_ready = 1'($urandom_range(1));
      end
      @(negedge clk);
      cyc++;
    end
    load_valid = 1'b0;
    if (idx < n) chk("replay_timeout", idx, n);
    chk("end_done", done, 1);
    chk("end_busy", busy, 0);
    chk("end_valid", cache_valid, 0);
    chk("end_addr_hold", cache_addr, m_addr[n-1]);
    chk("end_issued", num_issued, n);
    chk("end_rd", num_rd, n - exp_wr);
    chk("end_wr", num_wr, exp_wr);
    chk("end_ovf", overflow, m_ovf);
    if (stall_len > 0) chk("stall_cycles_seen", stalls, stall_len);
  endtask

  task automatic clear_buffer();
    clear = 1'b1; start = 1'b1; load_valid = 1'b1; load_addr = 48'h0BAD;
    @(negedge clk);
    clear = 1'b0; start = 1'b0; load_valid = 1'b0;
    m_addr.delete(); m_w.delete(); m_ovf = 0;
    chk("clr_ovf", overflow, 0);
    chk("clr_load_ready", load_ready, 1);
    chk("clr_start_ignored", busy, 0);
  endtask

  initial begin
    int xfers, cyc, n, keep;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk_reset_state();

    // Basic 3-entry trace, L1
    load_entry(48'h1000, 0);
    load_entry(48'h1040, 1);
    load_entry(48'h2000, 0);
    replay(1'b1, 100, -1, 0);

    // Replay from DONE at L2 with backpressure on entry 1
    replay(1'b0, 100, 1, 5);

    // Reset after the second accepted access
    start = 1'b1; lvl_sel = 1'b1;
    @(negedge clk);
    start = 1'b0; cache_ready = 1'b1;
    xfers = 0; cyc = 0;
    while (xfers < 2 && cyc < 100) begin
      if (cache_valid && cache_ready) xfers++;
      @(negedge clk);
      cyc++;
    end
    chk("pre_rst_xfers", xfers, 2);
    chk("pre_rst_issued", num_issued, 2);
    reset = 1'b1;
    @(negedge clk);
    chk_reset_state();
    reset = 1'b0;
    m_addr.delete(); m_w.delete(); m_ovf = 0;
    replay(1'b1, 100, -1, 0);

    // Fill to DEPTH, then one load too many
    for (int i = 0; i < DEPTH; i++) load_entry(ADDR_W'({$urandom, $urandom}), 1'($urandom_range(1)));
    load_entry(48'hDEAD_BEEF, 1);
    chk("full_count", m_addr.size(), DEPTH);
    replay(1'b1, 60, 5, 3);

    // Clear wins over same-cycle load and start; counters survive clear
    keep = DEPTH;
    clear_buffer();
    chk("clr_counters_kept", num_issued, keep);
    replay(1'b0, 100, -1, 0);

    // Randomized traces
    for (int r = 0; r < 4; r++) begin
      clear_buffer();
      n = $urandom_range(12, 1);
      for (int i = 0; i < n; i++) load_entry(ADDR_W'({$urandom, $urandom}), 1'($urandom_range(1)));
      replay(1'($urandom_range(1)), $urandom_range(100, 30), $urandom_range(n - 1), $urandom_range(4));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
